// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - op codes and controller state shared by the MIPS data memory
package mips_mem_pkg;
   typedef enum logic [1:0] {
      OP_LW = 2'b00,
      OP_SW = 2'b01,
      OP_LL = 2'b10,
      OP_SC = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word array with synchronous per-byte write and combinational read
module dmem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int NB    = DATA_W / 8
) (
   input  logic              clk,
   input  logic [NB-1:0]     we,
   input  logic [AW-1:0]     idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   assign rdata = mem[idx];
endmodule

// File: rtl/atomic_dmem_ctrl.sv
// rtl/atomic_dmem_ctrl.sv - req/done data memory with wait states and LL/SC reservation
// Optional DMEM_BYTE_EN_EN: honour be on SW and successful SC.
module atomic_dmem_ctrl
   import mips_mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic [1:0]          op,
   input  logic [31:0]         addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   rdata,
   output logic                resv_vld
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = DATA_W / 8;
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t                  state, state_nx;
   op_t                     op_q;
   logic [AW-1:0]           idx_q;
   logic [AW-1:0]           resv_idx;
   logic [DATA_W-1:0]       wdata_q;
   logic [DATA_W-1:0]       mem_rdata;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic [NB-1:0]           we;
   logic                    accept;
   logic                    resv_hit;
   logic                    do_write;
   logic                    unused_bits;

   assign accept   = (state == ST_IDLE) && req;
   assign resv_hit = resv_vld && (resv_idx == idx_q);
   assign do_write = (state == ST_RESP) &&
                     ((op_q == OP_SW) || ((op_q == OP_SC) && resv_hit));

`ifdef DMEM_BYTE_EN_EN
   logic [NB-1:0] be_q;
   assign we          = do_write ? be_q : '0;
   assign unused_bits = ^{addr[31:AW+2], addr[1:0]};
`else
   assign we          = {NB{do_write}};
   assign unused_bits = ^{addr[31:AW+2], addr[1:0], be};
`endif

   dmem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (req) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
         ST_WAIT: if (wait_cnt == '0) state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // RAM is touched only in RESP, so an async reset before then aborts cleanly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         resv_vld <= 1'b0;
         resv_idx <= '0;
         wait_cnt <= '0;
         op_q     <= OP_LW;
         idx_q    <= '0;
         wdata_q  <= '0;
`ifdef DMEM_BYTE_EN_EN
         be_q     <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            busy     <= 1'b1;
            op_q     <= op_t'(op);
            idx_q    <= addr[AW+1:2];
            wdata_q  <= wdata;
            wait_cnt <= WAIT_INIT;
`ifdef DMEM_BYTE_EN_EN
            be_q     <= be;
`endif
         end
         if ((state == ST_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - 1'b1;
         if (state == ST_RESP) begin
            busy <= 1'b0;
            done <= 1'b1;
            case (op_q)
               OP_LW: rdata <= mem_rdata;
               OP_SW: begin
                  rdata <= '0;
                  if (resv_hit) resv_vld <= 1'b0;
               end
               OP_LL: begin
                  rdata    <= mem_rdata;
                  resv_vld <= 1'b1;
                  resv_idx <= idx_q;
               end
               OP_SC: begin
                  rdata    <= {{(DATA_W-1){1'b0}}, resv_hit};
                  resv_vld <= 1'b0;
               end
               default: rdata <= '0;
            endcase
         end
      end
   end
endmodule
